qspi_burst_fsm: RTL and testbench
=================================

QSPI_BURST_FSM -- requirements
Module: qspi_burst_fsm

Interface
REQ-001 SHALL have parameter ADDRBITS, default 24: SPI address and memory-Wishbone address width.
REQ-002 SHALL have parameter DATABITS, default 16: memory word width, 1..IOREG_BITS.
REQ-003 SHALL have parameter IOREG_BITS, default 32: PHY data register width.
REQ-004 SHALL have parameter WAIT_CYC, default 8: dummy-phase bit count, 1..255.
REQ-005 SHALL have parameter WRAP_BITS, default 4: wrap-burst window is 2^WRAP_BITS words.
REQ-006 SHALL have parameters CMD_RD 8'h0B, CMD_RDW 8'h0C and CMD_WR 8'h02: linear-read, wrap-read and linear-write opcodes.
REQ-007 SHALL have ports clk_i in 1, the single clock; reset_ni in 1, asynchronous active-low reset.
REQ-008 SHALL have PHY ports txnen_o out 1 (phase request valid); txnbc_o out 8 (phase bit count); txndir_o out 1 (0 = receive from host, 1 = send to host); txndata_o out IOREG_BITS; txndata_i in IOREG_BITS; txndone_i in 1 (one-cycle phase complete); txnreset_i in 1 (CE deasserted).
REQ-009 SHALL have memory Wishbone (pipelined) ports memwb_cyc_o, memwb_stb_o, memwb_we_o out 1; memwb_adr_o out ADDRBITS; memwb_dat_o out DATABITS; memwb_ack_i, memwb_err_i, memwb_stall_i in 1; memwb_dat_i in DATABITS.
REQ-010 SHALL have status ports busy_o out 1 (state is not IDLE or CMD); err_o out 1 (sticky bus error); burst_cnt_o out 16 (words completed in current transaction).

Function
REQ-011 SHALL implement states IDLE, CMD, ADDR, WAIT, RDATA, WDATA, IGNORE, DRAIN.
REQ-012 IDLE SHALL go to CMD on the next cycle; CMD SHALL present txnen_o=1, txnbc_o=8, txndir_o=0.
REQ-013 On txndone_i in CMD: CMD_RD/CMD_RDW -> ADDR with the wrap flag latched; CMD_WR -> ADDR; any other opcode -> IGNORE; burst_cnt_o and err_o SHALL clear.
REQ-014 ADDR SHALL present txnbc_o=ADDRBITS, txndir_o=0; on txndone_i, address is latched from txndata_i[ADDRBITS-1:0]; reads go to WAIT and issue the first Wishbone read in the same cycle; writes go to WDATA.
REQ-015 WAIT SHALL present txnbc_o=WAIT_CYC, txndir_o=0, received data discarded; txndone_i -> RDATA.
REQ-016 RDATA SHALL assert txnen_o only while the one-word read buffer is full; txndata_o = buffer zero-extended to IOREG_BITS; txnbc_o=DATABITS; txndir_o=1.
REQ-017 On RDATA txndone_i: buffer empties, address advances, next read is issued next cycle, burst_cnt_o increments.
REQ-018 WDATA SHALL assert txnen_o only with no write outstanding; txnbc_o=DATABITS, txndir_o=0; on txndone_i, a write is issued with memwb_dat_o=txndata_i[DATABITS-1:0].
REQ-019 On write ack/err: address advances, burst_cnt_o increments, txnen_o reasserts next cycle.
REQ-020 Address advance: linear = +1 mod 2^ADDRBITS; wrap = low WRAP_BITS increment modulo 2^WRAP_BITS, upper bits unchanged.
REQ-021 Wishbone: cyc and stb rise together; stb held with constant adr/we/dat while memwb_stall_i=1, low the cycle after accepted; cyc held until ack or err; at most one request outstanding.
REQ-022 memwb_err_i SHALL complete the access, set err_o, and load all-ones into the read buffer.
REQ-023 burst_cnt_o SHALL saturate at 16'hFFFF.
REQ-024 txndone_i while txnen_o=0 SHALL be ignored; IGNORE holds txnen_o=0.
REQ-025 txnreset_i SHALL override all: txnen_o low same cycle, pending stb/buffer discarded; if an access is outstanding go to DRAIN (cyc held until ack/err, response discarded), else IDLE; DRAIN -> IDLE on ack/err.
REQ-026 txnreset_i coincident with txndone_i SHALL take priority; the phase is not consumed.

Reset
REQ-027 While reset_ni=0 SHALL force state IDLE, all Wishbone outputs 0, txnen_o=0, txnbc_o=0, txndir_o=0, txndata_o=0, busy_o=0, err_o=0, burst_cnt_o=0, address and buffer 0.
REQ-028 Reset SHALL assert asynchronously and release synchronously to clk_i; Wishbone cycles in progress are abandoned.

Verification
REQ-029 CMD_RD, addr 24'h000010, 3 words, ack 1 cycle, no stall -> reads at 10,11,12, txndata_o = mem words, burst_cnt_o=3.
REQ-030 CMD_RDW, addr 24'h00001E, 4 words -> reads at 1E,1F,10,11.
REQ-031 CMD_WR, addr 24'hFFFFFF, data 16'hA5A5,16'h5A5A, stall 2 cycles on first -> writes at FFFFFF then 000000, adr/dat stable during stall.
REQ-032 Read with memwb_err_i on word 2 -> word 2 = 16'hFFFF, err_o=1 until next CMD txndone_i.
REQ-033 txnreset_i while read outstanding, ack 5 cycles later -> DRAIN, cyc held to ack, then IDLE/CMD; opcode 8'h9F -> IGNORE, no Wishbone activity.
REQ-034 reset_ni low mid-write burst -> all outputs zero immediately; next command decoded normally after release.

Source files
------------

// File: rtl/qspi_burst_fsm.sv
// -----------------------------------------------------------------------------
// qspi_burst_fsm
//
// Bridges a QSPI slave PHY to a pipelined Wishbone memory port. The PHY is
// asked for one phase at a time (command byte, address, dummy cycles, data
// words); this block decodes the command, latches the start address, and
// streams words between the PHY and memory. It supports linear reads,
// wrapping reads (window of 2^WRAP_BITS words) and linear writes.
//
// Ports
//   clk_i, reset_ni        : clock, asynchronous active-low reset
//   txnen_o / txnbc_o      : phase request valid / phase bit count
//   txndir_o               : 0 = receive from host, 1 = send to host
//   txndata_o / txndata_i  : data to host / data received from host
//   txndone_i              : one-cycle pulse, requested phase completed
//   txnreset_i             : chip enable deasserted, abort transaction
//   memwb_*                : pipelined Wishbone master, one access in flight
//   busy_o                 : transaction past the command phase
//   err_o                  : sticky bus error, cleared by the next command
//   burst_cnt_o            : words completed in this transaction (saturates)
// -----------------------------------------------------------------------------
module qspi_burst_fsm #(
    parameter int         ADDRBITS   = 24,
    parameter int         DATABITS   = 16,
    parameter int         IOREG_BITS = 32,
    parameter int         WAIT_CYC   = 8,
    parameter int         WRAP_BITS  = 4,
    parameter logic [7:0] CMD_RD     = 8'h0B,
    parameter logic [7:0] CMD_RDW    = 8'h0C,
    parameter logic [7:0] CMD_WR     = 8'h02
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    // PHY phase interface
    output logic                  txnen_o,
    output logic [7:0]            txnbc_o,
    output logic                  txndir_o,
    output logic [IOREG_BITS-1:0] txndata_o,
    input  logic [IOREG_BITS-1:0] txndata_i,
    input  logic                  txndone_i,
    input  logic                  txnreset_i,
    // Memory Wishbone (pipelined)
    output logic                  memwb_cyc_o,
    output logic                  memwb_stb_o,
    output logic                  memwb_we_o,
    output logic [ADDRBITS-1:0]   memwb_adr_o,
    output logic [DATABITS-1:0]   memwb_dat_o,
    input  logic                  memwb_ack_i,
    input  logic                  memwb_err_i,
    input  logic                  memwb_stall_i,
    input  logic [DATABITS-1:0]   memwb_dat_i,
    // Status
    output logic                  busy_o,
    output logic                  err_o,
    output logic [15:0]           burst_cnt_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WAIT,
        S_RDATA,
        S_WDATA,
        S_IGNORE,
        S_DRAIN
    } state_t;

    // Bits of the address that move inside a wrap window.
    localparam logic [ADDRBITS-1:0] WRAP_MASK = ADDRBITS'((1 << WRAP_BITS) - 1);

    state_t                state_reg;
    logic                  wrap_reg;       // current burst wraps
    logic                  write_reg;      // current burst is a write
    logic [ADDRBITS-1:0]   addr_reg;       // address of the current word
    logic [DATABITS-1:0]   buf_reg;        // one-word read buffer
    logic                  buf_full_reg;
    logic                  cyc_reg;
    logic                  stb_reg;
    logic                  we_reg;
    logic [ADDRBITS-1:0]   adr_reg;
    logic [DATABITS-1:0]   wdat_reg;
    logic                  err_reg;
    logic [15:0]           cnt_reg;

    // Phase request decode, before the txnreset_i override.
    logic                  txnen_int;
    logic [7:0]            txnbc_int;
    logic                  txndir_int;
    logic [IOREG_BITS-1:0] txndata_int;

    logic                  phase_done;
    logic                  wb_resp;
    logic                  wb_accept;
    logic                  wb_outstanding;
    logic [ADDRBITS-1:0]   addr_inc;
    logic [ADDRBITS-1:0]   addr_adv;
    logic [15:0]           cnt_sat;
    logic                  unused_txndata;

    // The PHY data register is wider than what any single phase consumes.
    assign unused_txndata = ^txndata_i;

    always_comb begin
        txnen_int   = 1'b0;
        txnbc_int   = 8'd0;
        txndir_int  = 1'b0;
        txndata_int = '0;
        case (state_reg)
            S_CMD: begin
                txnen_int = 1'b1;
                txnbc_int = 8'd8;
            end
            S_ADDR: begin
                txnen_int = 1'b1;
                txnbc_int = 8'(ADDRBITS);
            end
            S_WAIT: begin
                txnen_int = 1'b1;
                txnbc_int = 8'(WAIT_CYC);
            end
            S_RDATA: begin
                // Only offer a word to the host once memory has delivered it.
                txnen_int   = buf_full_reg;
                txnbc_int   = 8'(DATABITS);
                txndir_int  = 1'b1;
                txndata_int = IOREG_BITS'(buf_reg);
            end
            S_WDATA: begin
                // Accept the next word only after the previous write finished.
                txnen_int = ~cyc_reg;
                txnbc_int = 8'(DATABITS);
            end
            default: begin
                txnen_int = 1'b0;
            end
        endcase
    end

    // Chip-enable release must drop the request in the same cycle.
    assign txnen_o   = txnen_int & ~txnreset_i;
    assign txnbc_o   = txnbc_int;
    assign txndir_o  = txndir_int;
    assign txndata_o = txndata_int;

    // A done pulse counts only against an active request; txnreset_i wins.
    assign phase_done = txndone_i & txnen_int & ~txnreset_i;

    assign wb_resp   = cyc_reg & (memwb_ack_i | memwb_err_i);
    assign wb_accept = stb_reg & ~memwb_stall_i;
    // An access the slave has taken (or takes this cycle) and not yet answered.
    assign wb_outstanding = cyc_reg & (~stb_reg | ~memwb_stall_i) & ~wb_resp;

    assign addr_inc = addr_reg + ADDRBITS'(1);
    assign addr_adv = wrap_reg ? ((addr_reg & ~WRAP_MASK) | (addr_inc & WRAP_MASK))
                               : addr_inc;
    assign cnt_sat  = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_reg    <= S_IDLE;
            wrap_reg     <= 1'b0;
            write_reg    <= 1'b0;
            addr_reg     <= '0;
            buf_reg      <= '0;
            buf_full_reg <= 1'b0;
            cyc_reg      <= 1'b0;
            stb_reg      <= 1'b0;
            we_reg       <= 1'b0;
            adr_reg      <= '0;
            wdat_reg     <= '0;
            err_reg      <= 1'b0;
            cnt_reg      <= 16'd0;
        end else if (txnreset_i) begin
            // Abort: drop any unaccepted strobe and buffered data. An access
            // the slave already owns must still be allowed to complete.
            stb_reg      <= 1'b0;
            buf_full_reg <= 1'b0;
            if (state_reg == S_DRAIN) begin
                if (wb_resp) begin
                    cyc_reg   <= 1'b0;
                    we_reg    <= 1'b0;
                    state_reg <= S_IDLE;
                end
            end else if (wb_outstanding) begin
                state_reg <= S_DRAIN;
            end else begin
                cyc_reg   <= 1'b0;
                we_reg    <= 1'b0;
                state_reg <= S_IDLE;
            end
        end else begin
            // Wishbone handshake bookkeeping.
            if (wb_accept) begin
                stb_reg <= 1'b0;
            end
            if (wb_resp) begin
                cyc_reg <= 1'b0;
                stb_reg <= 1'b0;
                we_reg  <= 1'b0;
            end

            // Completion of a live access. Drained responses are dropped.
            if (wb_resp && state_reg != S_DRAIN) begin
                if (memwb_err_i) begin
                    err_reg <= 1'b1;
                end
                if (we_reg) begin
                    addr_reg <= addr_adv;
                    cnt_reg  <= cnt_sat;
                end else begin
                    buf_reg      <= memwb_err_i ? {DATABITS{1'b1}} : memwb_dat_i;
                    buf_full_reg <= 1'b1;
                end
            end

            case (state_reg)
                S_IDLE: begin
                    state_reg <= S_CMD;
                end
                S_CMD: begin
                    if (phase_done) begin
                        cnt_reg <= 16'd0;
                        err_reg <= 1'b0;
                        if (txndata_i[7:0] == CMD_RD) begin
                            wrap_reg  <= 1'b0;
                            write_reg <= 1'b0;
                            state_reg <= S_ADDR;
                        end else if (txndata_i[7:0] == CMD_RDW) begin
                            wrap_reg  <= 1'b1;
                            write_reg <= 1'b0;
                            state_reg <= S_ADDR;
                        end else if (txndata_i[7:0] == CMD_WR) begin
                            wrap_reg  <= 1'b0;
                            write_reg <= 1'b1;
                            state_reg <= S_ADDR;
                        end else begin
                            state_reg <= S_IGNORE;
                        end
                    end
                end
                S_ADDR: begin
                    if (phase_done) begin
                        addr_reg <= txndata_i[ADDRBITS-1:0];
                        if (write_reg) begin
                            state_reg <= S_WDATA;
                        end else begin
                            // Prefetch the first word while dummy bits run.
                            state_reg <= S_WAIT;
                            cyc_reg   <= 1'b1;
                            stb_reg   <= 1'b1;
                            we_reg    <= 1'b0;
                            adr_reg   <= txndata_i[ADDRBITS-1:0];
                        end
                    end
                end
                S_WAIT: begin
                    if (phase_done) begin
                        state_reg <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (phase_done) begin
                        // Word delivered; fetch the following one.
                        buf_full_reg <= 1'b0;
                        addr_reg     <= addr_adv;
                        cnt_reg      <= cnt_sat;
                        cyc_reg      <= 1'b1;
                        stb_reg      <= 1'b1;
                        we_reg       <= 1'b0;
                        adr_reg      <= addr_adv;
                    end
                end
                S_WDATA: begin
                    if (phase_done) begin
                        cyc_reg  <= 1'b1;
                        stb_reg  <= 1'b1;
                        we_reg   <= 1'b1;
                        adr_reg  <= addr_reg;
                        wdat_reg <= txndata_i[DATABITS-1:0];
                    end
                end
                S_IGNORE: begin
                    // Unknown opcode: sit quietly until chip enable drops.
                end
                S_DRAIN: begin
                    if (wb_resp) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign memwb_cyc_o = cyc_reg;
    assign memwb_stb_o = stb_reg;
    assign memwb_we_o  = we_reg;
    assign memwb_adr_o = adr_reg;
    assign memwb_dat_o = wdat_reg;

    assign busy_o      = (state_reg != S_IDLE) && (state_reg != S_CMD);
    assign err_o       = err_reg;
    assign burst_cnt_o = cnt_reg;

endmodule

// File: tb/tb_qspi_burst_fsm.sv
// -----------------------------------------------------------------------------
// tb_qspi_burst_fsm
//
// Directed bench for qspi_burst_fsm: plays the PHY host side one phase at a
// time and models a pipelined Wishbone memory whose read data is a fixed
// function of the address. Every comparison goes through check_val.
// -----------------------------------------------------------------------------
module tb_qspi_burst_fsm;

    logic        clk = 1'b0;
    logic        reset_ni;
    logic        txnen_o;
    logic [7:0]  txnbc_o;
    logic        txndir_o;
    logic [31:0] txndata_o;
    logic [31:0] txndata_i;
    logic        txndone_i;
    logic        txnreset_i;
    logic        memwb_cyc_o;
    logic        memwb_stb_o;
    logic        memwb_we_o;
    logic [23:0] memwb_adr_o;
    logic [15:0] memwb_dat_o;
    logic        memwb_ack_i;
    logic        memwb_err_i;
    logic        memwb_stall_i;
    logic [15:0] memwb_dat_i;
    logic        busy_o;
    logic        err_o;
    logic [15:0] burst_cnt_o;

    int total = 0;
    int bad   = 0;

    // Memory model controls and access log.
    int          ack_delay   = 1;
    int          stall_first = 0;
    int          err_idx     = -1;
    logic        log_we[$];
    logic [23:0] log_adr[$];
    logic [15:0] log_dat[$];

    qspi_burst_fsm dut (
        .clk_i         (clk),
        .reset_ni      (reset_ni),
        .txnen_o       (txnen_o),
        .txnbc_o       (txnbc_o),
        .txndir_o      (txndir_o),
        .txndata_o     (txndata_o),
        .txndata_i     (txndata_i),
        .txndone_i     (txndone_i),
        .txnreset_i    (txnreset_i),
        .memwb_cyc_o   (memwb_cyc_o),
        .memwb_stb_o   (memwb_stb_o),
        .memwb_we_o    (memwb_we_o),
        .memwb_adr_o   (memwb_adr_o),
        .memwb_dat_o   (memwb_dat_o),
        .memwb_ack_i   (memwb_ack_i),
        .memwb_err_i   (memwb_err_i),
        .memwb_stall_i (memwb_stall_i),
        .memwb_dat_i   (memwb_dat_i),
        .busy_o        (busy_o),
        .err_o         (err_o),
        .burst_cnt_o   (burst_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [23:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    function automatic logic [31:0] log_adr_at(input int i);
        if (i < log_adr.size()) return 32'(log_adr[i]);
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] log_dat_at(input int i);
        if (i < log_dat.size()) return 32'(log_dat[i]);
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] log_we_at(input int i);
        if (i < log_we.size()) return 32'(log_we[i]);
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Run one PHY phase from a falling edge: wait for the request, check its
    // shape, present data and pulse txndone_i for one cycle.
    task automatic phase(input string tag, input logic [7:0] exp_bc, input logic exp_dir,
                         input logic [31:0] din, output logic [31:0] dout);
        int n = 0;
        dout = '0;
        while (!txnen_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_val({tag, "_en"}, 32'(txnen_o), 32'd1);
        if (txnen_o) begin
            check_val({tag, "_bc"}, 32'(txnbc_o), 32'(exp_bc));
            check_val({tag, "_dir"}, 32'(txndir_o), 32'(exp_dir));
            dout      = txndata_o;
            txndata_i = din;
            txndone_i = 1'b1;
            @(negedge clk);
            txndone_i = 1'b0;
            txndata_i = '0;
            $display("phase %s bc=%0d dir=%0d in=%h out=%h", tag, exp_bc, exp_dir, din, dout);
        end
    endtask

    task automatic pulse_txnreset();
        txnreset_i = 1'b1;
        @(negedge clk);
        txnreset_i = 1'b0;
    endtask

    task automatic clear_log();
        log_we.delete();
        log_adr.delete();
        log_dat.delete();
    endtask

    // Pipelined Wishbone memory model, driven on falling edges.
    initial begin : wb_slave
        logic        pending;
        logic        in_req;
        int          ack_wait;
        int          stall_left;
        logic        pend_err;
        logic        pend_we;
        logic [23:0] pend_adr;
        logic [23:0] cap_adr;
        logic [15:0] cap_dat;
        pending = 1'b0;
        in_req  = 1'b0;
        ack_wait = 0;
        stall_left = 0;
        pend_err = 1'b0;
        pend_we  = 1'b0;
        pend_adr = '0;
        cap_adr  = '0;
        cap_dat  = '0;
        memwb_ack_i   = 1'b0;
        memwb_err_i   = 1'b0;
        memwb_stall_i = 1'b0;
        memwb_dat_i   = '0;
        forever begin
            @(negedge clk);
            memwb_ack_i = 1'b0;
            memwb_err_i = 1'b0;
            memwb_dat_i = '0;
            if (!reset_ni) begin
                pending       = 1'b0;
                in_req        = 1'b0;
                memwb_stall_i = 1'b0;
            end else if (pending) begin
                memwb_stall_i = 1'b0;
                if (ack_wait == 0) begin
                    pending = 1'b0;
                    if (pend_err) memwb_err_i = 1'b1;
                    else          memwb_ack_i = 1'b1;
                    memwb_dat_i = pend_we ? 16'h0000 : mem_word(pend_adr);
                end else begin
                    ack_wait--;
                end
            end else if (memwb_cyc_o && memwb_stb_o) begin
                if (!in_req) begin
                    in_req     = 1'b1;
                    cap_adr    = memwb_adr_o;
                    cap_dat    = memwb_dat_o;
                    stall_left = (log_adr.size() == 0) ? stall_first : 0;
                end else begin
                    check_val("stall_adr", 32'(memwb_adr_o), 32'(cap_adr));
                    check_val("stall_dat", 32'(memwb_dat_o), 32'(cap_dat));
                end
                if (stall_left > 0) begin
                    memwb_stall_i = 1'b1;
                    stall_left--;
                end else begin
                    memwb_stall_i = 1'b0;
                    in_req   = 1'b0;
                    pending  = 1'b1;
                    ack_wait = ack_delay - 1;
                    pend_err = (log_adr.size() == err_idx);
                    pend_we  = memwb_we_o;
                    pend_adr = memwb_adr_o;
                    log_we.push_back(memwb_we_o);
                    log_adr.push_back(memwb_adr_o);
                    log_dat.push_back(memwb_dat_o);
                    $display("wb %s adr=%h dat=%h err=%0d", memwb_we_o ? "wr" : "rd",
                             memwb_adr_o, memwb_dat_o, pend_err);
                end
            end else begin
                memwb_stall_i = 1'b0;
                in_req        = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] d;
        int n;
        reset_ni   = 1'b0;
        txndata_i  = '0;
        txndone_i  = 1'b0;
        txnreset_i = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state.
        check_val("rst_cyc",   32'(memwb_cyc_o), 32'd0);
        check_val("rst_txnen", 32'(txnen_o), 32'd0);
        check_val("rst_busy",  32'(busy_o), 32'd0);
        check_val("rst_cnt",   32'(burst_cnt_o), 32'd0);
        reset_ni = 1'b1;

        // Linear read of three words from 0x000010.
        phase("t1_cmd", 8'd8, 1'b0, 32'h0B, d);
        phase("t1_addr", 8'd24, 1'b0, 32'h0000_0010, d);
        phase("t1_wait", 8'd8, 1'b0, 32'hFFFF_FFFF, d);
        for (int i = 0; i < 3; i++) begin
            phase("t1_rd", 8'd16, 1'b1, 32'h0, d);
            check_val("t1_data", d, {16'h0, mem_word(24'(24'h10 + i))});
        end
        repeat (4) @(negedge clk);
        check_val("t1_cnt", 32'(burst_cnt_o), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check_val("t1_adr", log_adr_at(i), 32'h10 + 32'(i));
            check_val("t1_we", log_we_at(i), 32'd0);
        end
        pulse_txnreset();
        check_val("t1_idle", 32'(busy_o), 32'd0);
        clear_log();

        // Wrapping read of four words from 0x00001E.
        phase("t2_cmd", 8'd8, 1'b0, 32'h0C, d);
        phase("t2_addr", 8'd24, 1'b0, 32'h0000_001E, d);
        phase("t2_wait", 8'd8, 1'b0, 32'h0, d);
        for (int i = 0; i < 4; i++) begin
            logic [23:0] a;
            a = (i == 0) ? 24'h1E : (i == 1) ? 24'h1F : (i == 2) ? 24'h10 : 24'h11;
            phase("t2_rd", 8'd16, 1'b1, 32'h0, d);
            check_val("t2_data", d, {16'h0, mem_word(a)});
            check_val("t2_adr", log_adr_at(i), 32'(a));
        end
        repeat (4) @(negedge clk);
        check_val("t2_cnt", 32'(burst_cnt_o), 32'd4);
        pulse_txnreset();
        clear_log();

        // Linear write across the top of the address space, first one stalled.
        stall_first = 2;
        phase("t3_cmd", 8'd8, 1'b0, 32'h02, d);
        phase("t3_addr", 8'd24, 1'b0, 32'h00FF_FFFF, d);
        phase("t3_wr", 8'd16, 1'b0, 32'h0000_A5A5, d);
        phase("t3_wr", 8'd16, 1'b0, 32'h0000_5A5A, d);
        repeat (4) @(negedge clk);
        check_val("t3_cnt", 32'(burst_cnt_o), 32'd2);
        check_val("t3_adr0", log_adr_at(0), 32'h00FF_FFFF);
        check_val("t3_dat0", log_dat_at(0), 32'h0000_A5A5);
        check_val("t3_we0",  log_we_at(0), 32'd1);
        check_val("t3_adr1", log_adr_at(1), 32'h0000_0000);
        check_val("t3_dat1", log_dat_at(1), 32'h0000_5A5A);
        check_val("t3_err",  32'(err_o), 32'd0);
        stall_first = 0;
        pulse_txnreset();
        clear_log();

        // Bus error on the second read word.
        err_idx = 1;
        phase("t4_cmd", 8'd8, 1'b0, 32'h0B, d);
        phase("t4_addr", 8'd24, 1'b0, 32'h0000_0020, d);
        phase("t4_wait", 8'd8, 1'b0, 32'h0, d);
        phase("t4_rd0", 8'd16, 1'b1, 32'h0, d);
        check_val("t4_data0", d, {16'h0, mem_word(24'h20)});
        phase("t4_rd1", 8'd16, 1'b1, 32'h0, d);
        check_val("t4_data1", d, 32'h0000_FFFF);
        phase("t4_rd2", 8'd16, 1'b1, 32'h0, d);
        check_val("t4_data2", d, {16'h0, mem_word(24'h22)});
        check_val("t4_err", 32'(err_o), 32'd1);
        repeat (4) @(negedge clk);
        err_idx = -1;
        pulse_txnreset();
        clear_log();

        // Abort with a read in flight, slow ack: must drain before idling.
        ack_delay = 5;
        @(negedge clk);
        check_val("t5_err_sticky", 32'(err_o), 32'd1);
        phase("t5_cmd", 8'd8, 1'b0, 32'h0B, d);
        check_val("t5_err_clr", 32'(err_o), 32'd0);
        phase("t5_addr", 8'd24, 1'b0, 32'h0000_0040, d);
        @(negedge clk);
        check_val("t5_outstanding", 32'(memwb_cyc_o), 32'd1);
        txnreset_i = 1'b1;
        #1;
        check_val("t5_en_override", 32'(txnen_o), 32'd0);
        @(negedge clk);
        txnreset_i = 1'b0;
        check_val("t5_drain_busy", 32'(busy_o), 32'd1);
        check_val("t5_drain_cyc", 32'(memwb_cyc_o), 32'd1);
        check_val("t5_drain_stb", 32'(memwb_stb_o), 32'd0);
        n = 0;
        while (memwb_cyc_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("t5_cyc_release", 32'(memwb_cyc_o), 32'd0);
        check_val("t5_held_to_ack", 32'(n >= 3), 32'd1);
        check_val("t5_idle", 32'(busy_o), 32'd0);
        ack_delay = 1;
        clear_log();
        // Unknown opcode: ignored, no memory traffic, stray done ignored.
        phase("t5_cmd9f", 8'd8, 1'b0, 32'h9F, d);
        check_val("t5_ign_busy", 32'(busy_o), 32'd1);
        check_val("t5_ign_en", 32'(txnen_o), 32'd0);
        txndone_i = 1'b1;
        @(negedge clk);
        txndone_i = 1'b0;
        repeat (3) @(negedge clk);
        check_val("t5_ign_busy2", 32'(busy_o), 32'd1);
        check_val("t5_ign_en2", 32'(txnen_o), 32'd0);
        check_val("t5_ign_cyc", 32'(memwb_cyc_o), 32'd0);
        check_val("t5_ign_wb", 32'(log_adr.size()), 32'd0);
        check_val("t5_ign_cnt", 32'(burst_cnt_o), 32'd0);
        pulse_txnreset();

        // Reset in the middle of a write burst.
        phase("t6_cmd", 8'd8, 1'b0, 32'h02, d);
        phase("t6_addr", 8'd24, 1'b0, 32'h0000_0100, d);
        phase("t6_wr", 8'd16, 1'b0, 32'h0000_1234, d);
        #2;
        reset_ni = 1'b0;
        #1;
        check_val("t6_rst_cyc", 32'(memwb_cyc_o), 32'd0);
        check_val("t6_rst_stb", 32'(memwb_stb_o), 32'd0);
        check_val("t6_rst_we",  32'(memwb_we_o), 32'd0);
        check_val("t6_rst_adr", 32'(memwb_adr_o), 32'd0);
        check_val("t6_rst_dat", 32'(memwb_dat_o), 32'd0);
        check_val("t6_rst_en",  32'(txnen_o), 32'd0);
        check_val("t6_rst_bc",  32'(txnbc_o), 32'd0);
        check_val("t6_rst_busy", 32'(busy_o), 32'd0);
        check_val("t6_rst_cnt", 32'(burst_cnt_o), 32'd0);
        check_val("t6_wr_seen", log_adr_at(0), 32'h0000_0100);
        repeat (2) @(negedge clk);
        reset_ni = 1'b1;
        clear_log();
        phase("t6_cmd2", 8'd8, 1'b0, 32'h0B, d);
        phase("t6_addr2", 8'd24, 1'b0, 32'h0000_0005, d);
        phase("t6_wait2", 8'd8, 1'b0, 32'h0, d);
        phase("t6_rd", 8'd16, 1'b1, 32'h0, d);
        check_val("t6_data", d, {16'h0, mem_word(24'h05)});
        check_val("t6_cnt", 32'(burst_cnt_o), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
